// File: rtl/teclado_pkg.sv
`default_nettype none
// ============================================================================
// teclado_pkg: shared key codes, FSM states and key classification helpers
// Revision: 1.0
// ============================================================================
package teclado_pkg;

  localparam logic [3:0] KEY_NEXT_DFLT = 4'hA;
  localparam logic [3:0] KEY_DONE_DFLT = 4'hB;
  localparam logic [3:0] KEY_CLR_DFLT  = 4'hC;
  localparam logic [3:0] KEY_DEL_DFLT  = 4'hD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  // E and F are reserved and are never accepted, whatever the command mapping
  function automatic logic is_reserved(input logic [3:0] code);
    return (code >= 4'hE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/module_flanco_tecla.sv
`default_nettype none
// ============================================================================
// module_flanco_tecla: one-shot key event on the rising edge of key_down,
// with the key code captured in the same cycle. Revision: 1.0
// ============================================================================
module module_flanco_tecla (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_down,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] event_code
);

  logic key_down_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_down_prev <= 1'b0;
      key_event     <= 1'b0;
      event_code    <= 4'd0;
    end else begin
      key_down_prev <= key_down;
      key_event     <= key_down & ~key_down_prev;
      if (key_down & ~key_down_prev) begin
        event_code <= key_code;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/module_captura_operandos.sv
`default_nettype none
// ============================================================================
// module_captura_operandos: keypad entry of NUM_OPS BCD operands of up to
// DIGITS digits, delivered over valid/ready. Revision: 1.0
// ============================================================================
module module_captura_operandos
  import teclado_pkg::*;
#(
  parameter int         NUM_OPS  = 2,
  parameter int         DIGITS   = 3,
  parameter logic [3:0] KEY_NEXT = KEY_NEXT_DFLT,
  parameter logic [3:0] KEY_DONE = KEY_DONE_DFLT,
  parameter logic [3:0] KEY_CLR  = KEY_CLR_DFLT,
  parameter logic [3:0] KEY_DEL  = KEY_DEL_DFLT,
  localparam int        OP_W     = 4 * DIGITS,
  localparam int        IDX_W    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
  localparam int        CNT_W    = $clog2(DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_down,
  input  logic [3:0]              key_code,
  input  logic                    ops_ready,
  output logic [NUM_OPS*OP_W-1:0] ops_data,
  output logic                    ops_valid,
  output logic [IDX_W-1:0]        op_index,
  output logic [CNT_W-1:0]        digit_count,
  output logic                    entry_active,
  output logic                    key_err
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_OPS - 1);
  localparam logic [CNT_W-1:0] MAX_DIGITS = CNT_W'(DIGITS);

  logic       key_event;
  logic [3:0] event_code;

  module_flanco_tecla u_flanco (
    .clk        (clk),
    .rst        (rst),
    .key_down   (key_down),
    .key_code   (key_code),
    .key_event  (key_event),
    .event_code (event_code)
  );

  state_t                         state_q, state_d;
  logic [NUM_OPS-1:0][OP_W-1:0]   ops_q, ops_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           err_d;
  logic [OP_W-1:0]                cur;

  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    cur     = ops_q[idx_q];

    unique case (state_q)
      IDLE: begin
        if (key_event) begin
          if (is_digit(event_code)) begin
            ops_d    = '0;
            ops_d[0] = OP_W'(event_code);
            idx_d    = '0;
            cnt_d    = CNT_W'(1);
            state_d  = ENTRY;
          end else if (is_reserved(event_code) || (event_code != KEY_CLR)) begin
            err_d = 1'b1;
          end
        end
      end

      ENTRY: begin
        if (key_event) begin
          if (is_reserved(event_code)) begin
            err_d = 1'b1;
          end else if (is_digit(event_code)) begin
            if (cnt_q < MAX_DIGITS) begin
              ops_d[idx_q] = (cur << 4) | OP_W'(event_code);
              cnt_d        = cnt_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (event_code == KEY_DEL) begin
            if (cnt_q != '0) begin
              ops_d[idx_q] = cur >> 4;
              cnt_d        = cnt_q - CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (event_code == KEY_CLR) begin
            ops_d[idx_q] = '0;
            cnt_d        = '0;
          end else if (event_code == KEY_NEXT) begin
            // An operand closed with no digits simply stays zero
            if (idx_q < LAST_IDX) begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (event_code == KEY_DONE) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      DONE: begin
        // Keys are silently ignored; ops_data is left for the display until the next entry
        if (ops_valid && ops_ready) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ops_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      ops_valid    <= 1'b0;
      entry_active <= 1'b0;
      key_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ops_q        <= ops_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      ops_valid    <= (state_d == DONE);
      entry_active <= (state_d == ENTRY);
      key_err      <= err_d;
    end
  end

  assign ops_data    = ops_q;
  assign op_index    = idx_q;
  assign digit_count = cnt_q;

endmodule
`default_nettype wire
